// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lock_pkg
// Purpose  : Shared types and constants for the serial password lock
//            (checker and setter use the same storage geometry).
// Revision : 1.0 - initial release
// ============================================================================
package lock_pkg;

  // Width of one password digit held in the storage register file.
  localparam int DIGIT_W   = 4;

  // Default password length, shared with the setter.
  localparam int PW_DIGITS = 4;

  // Checker state encoding; also exported on the debug port.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_PASS  = 3'd2,
    S_FAIL  = 3'd3,
    S_ALARM = 3'd4
  } CheckState;

endpackage
`default_nettype wire

// File: rtl/digit_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module   : digit_timeout_timer
// Purpose  : Idle-cycle counter between entered digits. Counts cycles with
//            tick=1, clears on clear=1, and flags expiry combinationally on
//            the cycle whose tick would reach TIMEOUT_CYCLES. Saturates at
//            the limit instead of wrapping. TIMEOUT_CYCLES=0 disables it.
// Revision : 1.0 - initial release
// ============================================================================
module digit_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      // No counter at all; inputs are intentionally left unused.
      logic w_unused_inputs;
      assign w_unused_inputs = &{1'b0, CLK, RST, clear, tick};
      assign expired = 1'b0;
    end else begin : g_enabled
      localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT_CYCLES);
      localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

      logic [CNT_W-1:0] r_count;

      // Idle counter: cleared by reset or clear, saturates at the limit.
      always_ff @(posedge CLK) begin
        if (RST || clear) begin
          r_count <= '0;
        end else if (tick && (r_count != c_limit)) begin
          r_count <= r_count + c_one;
        end
      end

      // Expiry fires on the idle cycle that would bring the count to the limit,
      // so an enable in that same cycle (tick=0) pre-empts it.
      assign expired = tick && (r_count == (c_limit - c_one));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/password_checker.sv
`default_nettype none
// ============================================================================
// Module   : password_checker
// Purpose  : Read side of the serial password lock. Consumes DIGITS digits
//            (one per enable strobe), compares each against the stored digit
//            at the current address, and reports unlock / fail / alarm.
// Revision : 1.0 - initial release
// ============================================================================
module password_checker
  import lock_pkg::*;
#(
  parameter  int DIGITS         = PW_DIGITS,
  parameter  int MAX_FAILS      = 3,
  parameter  int TIMEOUT_CYCLES = 0,
  localparam int ADDR_W         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               enable,
  input  logic [DIGIT_W-1:0] digit,
  input  logic [DIGIT_W-1:0] storedDigit,
  output logic [ADDR_W-1:0]  address,
  output logic               unlocked,
  output logic               alarm,
  output logic [3:0]         failCount,
  output logic [2:0]         dbgCheckState
);

  localparam logic [ADDR_W-1:0] c_last_idx  = ADDR_W'(DIGITS - 1);
  localparam logic [ADDR_W-1:0] c_idx_one   = ADDR_W'(1);
  localparam logic [3:0]        c_max_fails = 4'(MAX_FAILS);
  localparam logic [4:0]        c_max_ext   = 5'(MAX_FAILS);

  CheckState         r_state;
  CheckState         w_state_next;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_next;
  logic              r_mismatch;
  logic              w_mismatch_next;
  logic [3:0]        r_failCount;
  logic [3:0]        w_failCount_next;
  logic              w_mis_acc;
  logic              w_digit_bad;
  logic              w_in_entry;
  logic              w_expired;

  assign w_in_entry  = (r_state == S_ENTRY);
  assign w_digit_bad = (digit != storedDigit);

  // Idle timer only runs mid-entry; any strobe or any other state clears it.
  digit_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (enable || !w_in_entry),
    .tick    (w_in_entry && !enable),
    .expired (w_expired)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_mismatch  <= 1'b0;
      r_failCount <= '0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_mismatch  <= w_mismatch_next;
      r_failCount <= w_failCount_next;
    end
  end

  // Next-state: accept digits, produce a verdict after the last one, handle timeout.
  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_mismatch_next  = r_mismatch;
    w_failCount_next = r_failCount;
    w_mis_acc        = 1'b0;

    case (r_state)
      S_IDLE, S_ENTRY, S_PASS, S_FAIL: begin
        if (enable) begin
          // A strobe outside S_ENTRY begins a fresh attempt: prior mismatch is dropped.
          w_mis_acc = (w_in_entry ? r_mismatch : 1'b0) | w_digit_bad;
          if (r_idx == c_last_idx) begin
            // Every digit is always consumed; the verdict comes only here.
            w_idx_next      = '0;
            w_mismatch_next = 1'b0;
            if (!w_mis_acc) begin
              w_state_next     = S_PASS;
              w_failCount_next = '0;
            end else if (({1'b0, r_failCount} + 5'd1) == c_max_ext) begin
              w_state_next     = S_ALARM;
              w_failCount_next = c_max_fails;
            end else begin
              w_state_next     = S_FAIL;
              w_failCount_next = r_failCount + 4'd1;
            end
          end else begin
            w_state_next    = S_ENTRY;
            w_idx_next      = r_idx + c_idx_one;
            w_mismatch_next = w_mis_acc;
          end
        end else if (w_in_entry && w_expired) begin
          // Abandoned entry: back to idle without counting a failure.
          w_state_next    = S_IDLE;
          w_idx_next      = '0;
          w_mismatch_next = 1'b0;
        end
      end

      S_ALARM: begin
        // Frozen until reset.
        w_state_next = S_ALARM;
      end

      default: begin
        w_state_next    = S_IDLE;
        w_idx_next      = '0;
        w_mismatch_next = 1'b0;
      end
    endcase
  end

  assign address       = r_idx;
  assign unlocked      = (r_state == S_PASS);
  assign alarm         = (r_state == S_ALARM);
  assign failCount     = r_failCount;
  assign dbgCheckState = r_state;

endmodule
`default_nettype wire

// File: tb/tb_password_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_password_checker
// Purpose  : Self-checking bench for password_checker. Storage holds 1,2,3,4;
//            MAX_FAILS=3. Main instance uses TIMEOUT_CYCLES=8, a second
//            instance uses TIMEOUT_CYCLES=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_password_checker;
  import lock_pkg::*;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] dig;
    logic [2:0] st;
    logic [1:0] ad;
    logic       un;
    logic       al;
    logic [3:0] fc;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       enable;
  logic [3:0] digit;

  logic [3:0] mem [4];

  logic [1:0] address,  address0;
  logic       unlocked, unlocked0;
  logic       alarm,    alarm0;
  logic [3:0] failCount, failCount0;
  logic [2:0] dbg,      dbg0;
  logic [3:0] stored,   stored0;

  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;

  vec_t tbl[$];
  vec_t sb[$];

  always #5 CLK = ~CLK;

  // Combinational storage read for each instance.
  assign stored  = mem[address];
  assign stored0 = mem[address0];

  password_checker #(.DIGITS(4), .MAX_FAILS(3), .TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .digit(digit), .storedDigit(stored),
    .address(address), .unlocked(unlocked), .alarm(alarm),
    .failCount(failCount), .dbgCheckState(dbg)
  );

  password_checker #(.DIGITS(4), .MAX_FAILS(3), .TIMEOUT_CYCLES(0)) dut0 (
    .CLK(CLK), .RST(RST), .enable(enable), .digit(digit), .storedDigit(stored0),
    .address(address0), .unlocked(unlocked0), .alarm(alarm0),
    .failCount(failCount0), .dbgCheckState(dbg0)
  );

  function automatic vec_t v(input logic r, input logic e, input logic [3:0] d,
                             input logic [2:0] s, input logic [1:0] a,
                             input logic u, input logic l, input logic [3:0] f);
    vec_t x;
    x.rst = r; x.en = e; x.dig = d; x.st = s; x.ad = a; x.un = u; x.al = l; x.fc = f;
    return x;
  endfunction

  task automatic check_dut();
    vec_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL step%0d: scoreboard empty", step_no);
    end else begin
      e = sb.pop_front();
      if ({dbg, address, unlocked, alarm, failCount} !== {e.st, e.ad, e.un, e.al, e.fc}) begin
        n_fail++;
        $display("FAIL step%0d: got state=%0d addr=%0d unl=%0b alarm=%0b fc=%0d, expected state=%0d addr=%0d unl=%0b alarm=%0b fc=%0d",
                 step_no, dbg, address, unlocked, alarm, failCount, e.st, e.ad, e.un, e.al, e.fc);
      end
    end
  endtask

  task automatic check_dut0(input string name, input logic [2:0] s, input logic [1:0] a,
                            input logic u, input logic l, input logic [3:0] f);
    n_checks++;
    if ({dbg0, address0, unlocked0, alarm0, failCount0} !== {s, a, u, l, f}) begin
      n_fail++;
      $display("FAIL %s: got state=%0d addr=%0d unl=%0b alarm=%0b fc=%0d, expected state=%0d addr=%0d unl=%0b alarm=%0b fc=%0d",
               name, dbg0, address0, unlocked0, alarm0, failCount0, s, a, u, l, f);
    end
  endtask

  // Drive one cycle of stimulus, push its expectation, then compare after the edge.
  task automatic apply(input vec_t x);
    sb.push_back(x);
    RST    = x.rst;
    enable = x.en;
    digit  = x.dig;
    @(posedge CLK);
    #1;
    step_no++;
    check_dut();
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] d,
                      input logic [2:0] s, input logic [1:0] a,
                      input logic u, input logic l, input logic [3:0] f);
    apply(v(r, e, d, s, a, u, l, f));
  endtask

  initial begin
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd3; mem[3] = 4'd4;
    RST = 1'b1; enable = 1'b0; digit = 4'd0;

    // ---------------- table: reset, correct entry, fail/pass, alarm ----------------
    tbl.push_back(v(1, 0, 0, S_IDLE, 0, 0, 0, 0));
    // Correct password
    tbl.push_back(v(0, 1, 1, S_ENTRY, 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 2, S_ENTRY, 2, 0, 0, 0));
    tbl.push_back(v(0, 1, 3, S_ENTRY, 3, 0, 0, 0));
    tbl.push_back(v(0, 1, 4, S_PASS,  0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, S_PASS,  0, 1, 0, 0));
    // Wrong first digit, no early verdict
    tbl.push_back(v(0, 1, 9, S_ENTRY, 1, 0, 0, 0));
    tbl.push_back(v(0, 1, 2, S_ENTRY, 2, 0, 0, 0));
    tbl.push_back(v(0, 1, 3, S_ENTRY, 3, 0, 0, 0));
    tbl.push_back(v(0, 1, 4, S_FAIL,  0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, S_FAIL,  0, 0, 0, 1));
    // Correct entry clears fail count
    tbl.push_back(v(0, 1, 1, S_ENTRY, 1, 0, 0, 1));
    tbl.push_back(v(0, 1, 2, S_ENTRY, 2, 0, 0, 1));
    tbl.push_back(v(0, 1, 3, S_ENTRY, 3, 0, 0, 1));
    tbl.push_back(v(0, 1, 4, S_PASS,  0, 1, 0, 0));
    // Three wrong attempts -> alarm
    for (int a = 0; a < 3; a++) begin
      for (int k = 1; k < 4; k++)
        tbl.push_back(v(0, 1, 5, S_ENTRY, 2'(k), 0, 0, 4'(a)));
      if (a < 2) tbl.push_back(v(0, 1, 5, S_FAIL,  0, 0, 0, 4'(a + 1)));
      else       tbl.push_back(v(0, 1, 5, S_ALARM, 0, 0, 1, 4'd3));
    end
    // Correct password ignored while in alarm
    for (int k = 1; k <= 4; k++)
      tbl.push_back(v(0, 1, 4'(k), S_ALARM, 0, 0, 1, 3));
    tbl.push_back(v(1, 0, 0, S_IDLE, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // ---------------- timeout: abandoned entry keeps fail count ----------------
    for (int k = 1; k < 4; k++) step(0, 1, 5, S_ENTRY, 2'(k), 0, 0, 0);
    step(0, 1, 5, S_FAIL, 0, 0, 0, 1);
    step(0, 1, 1, S_ENTRY, 1, 0, 0, 1);
    step(0, 1, 2, S_ENTRY, 2, 0, 0, 1);
    for (int k = 0; k < 7; k++) step(0, 0, 0, S_ENTRY, 2, 0, 0, 1);
    step(0, 0, 0, S_IDLE, 0, 0, 0, 1);
    // Enable on the cycle that would expire wins
    step(0, 1, 1, S_ENTRY, 1, 0, 0, 1);
    step(0, 1, 2, S_ENTRY, 2, 0, 0, 1);
    for (int k = 0; k < 7; k++) step(0, 0, 0, S_ENTRY, 2, 0, 0, 1);
    step(0, 1, 3, S_ENTRY, 3, 0, 0, 1);
    step(0, 1, 4, S_PASS,  0, 1, 0, 0);

    // ---------------- reset mid-entry ----------------
    step(1, 0, 0, S_IDLE, 0, 0, 0, 0);
    step(0, 1, 1, S_ENTRY, 1, 0, 0, 0);
    step(0, 1, 2, S_ENTRY, 2, 0, 0, 0);
    step(0, 1, 3, S_ENTRY, 3, 0, 0, 0);
    step(1, 1, 4, S_IDLE, 0, 0, 0, 0);
    step(0, 1, 1, S_ENTRY, 1, 0, 0, 0);
    step(0, 1, 2, S_ENTRY, 2, 0, 0, 0);
    step(0, 1, 3, S_ENTRY, 3, 0, 0, 0);
    step(0, 1, 4, S_PASS,  0, 1, 0, 0);

    // ---------------- new attempt from S_PASS, wrong last digit ----------------
    step(0, 1, 1, S_ENTRY, 1, 0, 0, 0);
    step(0, 1, 2, S_ENTRY, 2, 0, 0, 0);
    step(0, 1, 3, S_ENTRY, 3, 0, 0, 0);
    step(0, 1, 5, S_FAIL,  0, 0, 0, 1);

    // ---------------- TIMEOUT_CYCLES=0: no timeout after long idle ----------------
    step(1, 0, 0, S_IDLE, 0, 0, 0, 0);
    check_dut0("t0_reset", S_IDLE, 0, 0, 0, 0);
    step(0, 1, 1, S_ENTRY, 1, 0, 0, 0);
    step(0, 1, 2, S_ENTRY, 2, 0, 0, 0);
    RST = 1'b0; enable = 1'b0; digit = 4'd0;
    repeat (1000) @(posedge CLK);
    #1;
    check_dut0("t0_idle1000", S_ENTRY, 2, 0, 0, 0);
    n_checks++;
    if (dbg !== S_IDLE) begin
      n_fail++;
      $display("FAIL t8_idle1000: got state=%0d, expected state=%0d", dbg, S_IDLE);
    end
    enable = 1'b1; digit = 4'd3;
    @(posedge CLK); #1;
    check_dut0("t0_dig3", S_ENTRY, 3, 0, 0, 0);
    digit = 4'd4;
    @(posedge CLK); #1;
    check_dut0("t0_dig4", S_PASS, 0, 1, 0, 0);
    enable = 1'b0;

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
